// File: rtl/lcd_id_pkg.sv
// Shared types and constants for LCD panel-ID strap detection.
// Latency: n/a (package only).
// Backpressure: n/a.
package lcd_id_pkg;

    typedef enum logic [1:0] {
        ST_SETTLE = 2'd0,
        ST_SAMPLE = 2'd1,
        ST_DECODE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Strap codes {M2,M1,M0}, named after the panel ID each selects
    localparam logic [2:0] CODE_4342 = 3'b000;
    localparam logic [2:0] CODE_7084 = 3'b001;
    localparam logic [2:0] CODE_7016 = 3'b010;
    localparam logic [2:0] CODE_4384 = 3'b100;
    localparam logic [2:0] CODE_1018 = 3'b101;

    localparam logic [15:0] ID_4342 = 16'h4342;
    localparam logic [15:0] ID_7084 = 16'h7084;
    localparam logic [15:0] ID_7016 = 16'h7016;
    localparam logic [15:0] ID_4384 = 16'h4384;
    localparam logic [15:0] ID_1018 = 16'h1018;

    localparam logic [10:0] H_480  = 11'd480;
    localparam logic [10:0] H_800  = 11'd800;
    localparam logic [10:0] H_1024 = 11'd1024;
    localparam logic [10:0] H_1280 = 11'd1280;
    localparam logic [10:0] V_272  = 11'd272;
    localparam logic [10:0] V_480  = 11'd480;
    localparam logic [10:0] V_600  = 11'd600;
    localparam logic [10:0] V_800  = 11'd800;

    typedef struct packed {
        logic [15:0] id;
        logic [10:0] h;
        logic [10:0] v;
    } panel_t;

endpackage

// File: rtl/lcd_id_if.sv
// Strap input bus and decoded panel-ID result bundle.
// Latency: n/a (wires only).
// Backpressure: none; results are level signals qualified by id_valid/id_err.
interface lcd_id_if;
    logic [15:0] lcd_rgb;
    logic        rescan;
    logic [15:0] lcd_id;
    logic [10:0] h_disp;
    logic [10:0] v_disp;
    logic [2:0]  strap_code;
    logic        id_valid;
    logic        id_err;
    logic        busy;

    modport master (
        output lcd_rgb, rescan,
        input  lcd_id, h_disp, v_disp, strap_code, id_valid, id_err, busy
    );

    modport slave (
        input  lcd_rgb, rescan,
        output lcd_id, h_disp, v_disp, strap_code, id_valid, id_err, busy
    );
endinterface

// File: rtl/lcd_id_lut.sv
// Strap code to panel ID / resolution lookup, with per-code enable mask.
// Latency: combinational.
// Backpressure: none.
module lcd_id_lut
    import lcd_id_pkg::*;
#(
    parameter logic [7:0] CODE_EN = 8'b0011_0111
) (
    input  logic [2:0] code,
    output panel_t     panel,
    output logic       bad
);

    // Table lookup; reserved or masked codes report bad with a zeroed panel
    always_comb begin
        panel = '0;
        bad   = 1'b0;
        case (code)
            CODE_4342: panel = '{id: ID_4342, h: H_480,  v: V_272};
            CODE_7084: panel = '{id: ID_7084, h: H_800,  v: V_480};
            CODE_7016: panel = '{id: ID_7016, h: H_1024, v: V_600};
            CODE_4384: panel = '{id: ID_4384, h: H_800,  v: V_480};
            CODE_1018: panel = '{id: ID_1018, h: H_1280, v: V_800};
            default:   bad   = 1'b1;
        endcase
        if (!CODE_EN[code]) begin
            bad = 1'b1;
        end
        if (bad) begin
            panel = '0;
        end
    end

endmodule

// File: rtl/lcd_id_detect.sv
// Debounced LCD panel strap detector: settle, repeated sampling, table decode.
// Latency: id_valid at edge SETTLE_CYCLES+(SAMPLE_NUM-1)*SAMPLE_GAP+2 after start.
// Backpressure: none; rescan is only honoured once a result is held in DONE.
module lcd_id_detect
    import lcd_id_pkg::*;
#(
    parameter int         SETTLE_CYCLES = 16,  // >= 2 so the synchronizer is primed
    parameter int         SAMPLE_NUM    = 4,   // 2..15
    parameter int         SAMPLE_GAP    = 8,   // >= 1
    parameter int         MAX_RETRY     = 3,   // >= 1
    parameter int         M2_POS        = 4,
    parameter int         M1_POS        = 10,
    parameter int         M0_POS        = 15,
    parameter logic [7:0] CODE_EN       = 8'b0011_0111
) (
    input  logic    clk,
    input  logic    rst_n,
    lcd_id_if.slave bus
);

    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam int GAP_W = $clog2(SAMPLE_GAP + 1);
    localparam int RTY_W = $clog2(MAX_RETRY + 1);

    logic [2:0]       pins;
    logic [2:0]       sync1_q, sync1_d, sync2_q, sync2_d;
    state_t           state_q, state_d;
    logic [SET_W-1:0] settle_cnt_q, settle_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [3:0]       smp_cnt_q, smp_cnt_d;
    logic [RTY_W-1:0] retry_q, retry_d;
    logic [2:0]       ref_q, ref_d;
    logic             force_err_q, force_err_d;
    panel_t           panel_q, panel_d;
    logic [2:0]       strap_q, strap_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    panel_t           lut_panel;
    logic             lut_bad;

    assign pins = {bus.lcd_rgb[M2_POS], bus.lcd_rgb[M1_POS], bus.lcd_rgb[M0_POS]};

    lcd_id_lut #(.CODE_EN(CODE_EN)) u_lut (
        .code  (ref_q),
        .panel (lut_panel),
        .bad   (lut_bad)
    );

    // Next-state: synchronizer shift, detection FSM, counters and result capture
    always_comb begin
        sync1_d      = pins;
        sync2_d      = sync1_q;
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        smp_cnt_d    = smp_cnt_q;
        retry_d      = retry_q;
        ref_d        = ref_q;
        force_err_d  = force_err_q;
        panel_d      = panel_q;
        strap_d      = strap_q;
        valid_d      = valid_q;
        err_d        = err_q;
        case (state_q)
            ST_SETTLE: begin
                if (settle_cnt_q == SET_W'(SETTLE_CYCLES - 1)) begin
                    state_d      = ST_SAMPLE;
                    settle_cnt_d = '0;
                    gap_cnt_d    = '0;
                    smp_cnt_d    = '0;
                end else begin
                    settle_cnt_d = settle_cnt_q + SET_W'(1);
                end
            end
            ST_SAMPLE: begin
                if (gap_cnt_q != '0) begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end else begin
                    gap_cnt_d = GAP_W'(SAMPLE_GAP - 1);
                    ref_d     = sync2_q;
                    if (smp_cnt_q == 4'd0 || sync2_q == ref_q) begin
                        smp_cnt_d = smp_cnt_q + 4'd1;
                        if (smp_cnt_q == 4'(SAMPLE_NUM - 1)) begin
                            state_d   = ST_DECODE;
                            gap_cnt_d = '0;
                            smp_cnt_d = '0;
                        end
                    end else begin
                        // A mismatching sample starts a fresh run as its own reference
                        smp_cnt_d = 4'd1;
                        retry_d   = retry_q + RTY_W'(1);
                        if (retry_q == RTY_W'(MAX_RETRY - 1)) begin
                            force_err_d = 1'b1;
                            state_d     = ST_DECODE;
                            gap_cnt_d   = '0;
                            smp_cnt_d   = '0;
                        end
                    end
                end
            end
            ST_DECODE: begin
                state_d = ST_DONE;
                strap_d = ref_q;
                if (lut_bad || force_err_q) begin
                    panel_d = '0;
                    valid_d = 1'b0;
                    err_d   = 1'b1;
                end else begin
                    panel_d = lut_panel;
                    valid_d = 1'b1;
                    err_d   = 1'b0;
                end
            end
            ST_DONE: begin
                // Panel fields are kept so downstream timing stays put during re-scan
                if (bus.rescan) begin
                    state_d      = ST_SETTLE;
                    valid_d      = 1'b0;
                    err_d        = 1'b0;
                    settle_cnt_d = '0;
                    gap_cnt_d    = '0;
                    smp_cnt_d    = '0;
                    retry_d      = '0;
                    force_err_d  = 1'b0;
                end
            end
            default: state_d = ST_SETTLE;
        endcase
    end

    // State register with asynchronous reset to the power-on detection state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            state_q      <= ST_SETTLE;
            settle_cnt_q <= '0;
            gap_cnt_q    <= '0;
            smp_cnt_q    <= '0;
            retry_q      <= '0;
            ref_q        <= '0;
            force_err_q  <= 1'b0;
            panel_q      <= '0;
            strap_q      <= '0;
            valid_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            smp_cnt_q    <= smp_cnt_d;
            retry_q      <= retry_d;
            ref_q        <= ref_d;
            force_err_q  <= force_err_d;
            panel_q      <= panel_d;
            strap_q      <= strap_d;
            valid_q      <= valid_d;
            err_q        <= err_d;
        end
    end

    assign bus.lcd_id     = panel_q.id;
    assign bus.h_disp     = panel_q.h;
    assign bus.v_disp     = panel_q.v;
    assign bus.strap_code = strap_q;
    assign bus.id_valid   = valid_q;
    assign bus.id_err     = err_q;
    assign bus.busy       = (state_q != ST_DONE);

endmodule

// File: tb/tb_lcd_id_detect.sv
module tb_lcd_id_detect;

    localparam int         SC  = 4;
    localparam int         SN  = 3;
    localparam int         SG  = 2;
    localparam int         MR  = 3;
    localparam logic [7:0] EN0 = 8'b0011_0111;
    localparam logic [7:0] EN1 = 8'b0011_0011;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] rgb = 16'h0;
    logic        rescan = 1'b0;

    always #5 clk = ~clk;

    lcd_id_if bus0();
    lcd_id_if bus1();

    assign bus0.lcd_rgb = rgb;
    assign bus0.rescan  = rescan;
    assign bus1.lcd_rgb = rgb;
    assign bus1.rescan  = rescan;

    lcd_id_detect #(.SETTLE_CYCLES(SC), .SAMPLE_NUM(SN), .SAMPLE_GAP(SG), .MAX_RETRY(MR),
                    .M2_POS(4), .M1_POS(10), .M0_POS(15), .CODE_EN(EN0))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

    lcd_id_detect #(.SETTLE_CYCLES(SC), .SAMPLE_NUM(SN), .SAMPLE_GAP(SG), .MAX_RETRY(MR),
                    .M2_POS(4), .M1_POS(10), .M0_POS(15), .CODE_EN(EN1))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    logic [15:0] o_id [2];
    logic [10:0] o_h [2];
    logic [10:0] o_v [2];
    logic [2:0]  o_code [2];
    logic        o_valid [2];
    logic        o_err [2];
    logic        o_busy [2];

    assign o_id[0] = bus0.lcd_id;      assign o_id[1] = bus1.lcd_id;
    assign o_h[0] = bus0.h_disp;       assign o_h[1] = bus1.h_disp;
    assign o_v[0] = bus0.v_disp;       assign o_v[1] = bus1.v_disp;
    assign o_code[0] = bus0.strap_code; assign o_code[1] = bus1.strap_code;
    assign o_valid[0] = bus0.id_valid; assign o_valid[1] = bus1.id_valid;
    assign o_err[0] = bus0.id_err;     assign o_err[1] = bus1.id_err;
    assign o_busy[0] = bus0.busy;      assign o_busy[1] = bus1.busy;

    int checks = 0;
    int failures = 0;

    // Strap pattern: code_a before chg_at, then code_b (or alternating a/b every 2 cycles)
    logic [2:0] code_a, code_b;
    int         chg_at;
    bit         tog;

    // Last expected result per DUT, used for hold and rescan checks
    logic [15:0] exp_id [2];
    logic [10:0] exp_h [2];
    logic [10:0] exp_v [2];
    logic [2:0]  exp_code [2];
    logic        exp_valid [2];
    logic        exp_err [2];

    function automatic logic [2:0] pin_at(int k);
        if (k < chg_at) return code_a;
        if (tog && (((k - chg_at) / 2) % 2) == 1) return code_a;
        return code_b;
    endfunction

    function automatic logic [15:0] make_rgb(logic [2:0] c);
        logic [15:0] r;
        r = 16'($urandom);
        r[15] = c[0];
        r[10] = c[1];
        r[4]  = c[2];
        return r;
    endfunction

    // Panel table as written in the datasheet, with the enable mask applied
    task automatic ref_decode(input logic [2:0] c, input logic [7:0] en, output logic [15:0] id,
                              output logic [10:0] h, output logic [10:0] v, output bit bad);
        bad = 0; id = 16'h0; h = 11'd0; v = 11'd0;
        case (c)
            3'b000: begin id = 16'h4342; h = 11'd480;  v = 11'd272; end
            3'b001: begin id = 16'h7084; h = 11'd800;  v = 11'd480; end
            3'b010: begin id = 16'h7016; h = 11'd1024; v = 11'd600; end
            3'b100: begin id = 16'h4384; h = 11'd800;  v = 11'd480; end
            3'b101: begin id = 16'h1018; h = 11'd1280; v = 11'd800; end
            default: bad = 1;
        endcase
        if (!en[c]) bad = 1;
    endtask

    // Walk the sample instants (pins seen 3 cycles late through the synchronizer)
    task automatic predict(output int done, output logic [2:0] rc, output bit forced);
        int t, run, retry;
        logic [2:0] c;
        t = SC + 1; rc = pin_at(t - 3); run = 1; retry = 0; forced = 0;
        while (run < SN && !forced) begin
            t = t + SG;
            c = pin_at(t - 3);
            if (c == rc) run++;
            else begin
                retry++; rc = c; run = 1;
                if (retry >= MR) forced = 1;
            end
        end
        done = t + 1;
    endtask

    task automatic do_reset(input string name);
        rst_n = 1'b0; rescan = 1'b0;
        rgb = make_rgb(pin_at(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (o_id[d] !== 16'h0 || o_h[d] !== 11'd0 || o_v[d] !== 11'd0 || o_code[d] !== 3'b000 ||
                o_valid[d] !== 1'b0 || o_err[d] !== 1'b0 || o_busy[d] !== 1'b1) begin
                failures++;
                $display("FAIL %s dut%0d: id=%h h=%0d v=%0d code=%b valid=%b err=%b busy=%b, required all zero with busy=1",
                         name, d, o_id[d], o_h[d], o_v[d], o_code[d], o_valid[d], o_err[d], o_busy[d]);
            end
            exp_id[d] = 16'h0; exp_h[d] = 11'd0; exp_v[d] = 11'd0; exp_code[d] = 3'b000;
            exp_valid[d] = 1'b0; exp_err[d] = 1'b0;
        end
        rst_n = 1'b1;
    endtask

    task automatic start_rescan(input string name);
        @(posedge clk); #1 rescan = 1'b1;
        @(posedge clk); #1 rescan = 1'b0;
        rgb = make_rgb(pin_at(0));
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (o_valid[d] !== 1'b0 || o_err[d] !== 1'b0 || o_busy[d] !== 1'b1 ||
                o_id[d] !== exp_id[d] || o_h[d] !== exp_h[d] || o_v[d] !== exp_v[d]) begin
                failures++;
                $display("FAIL %s dut%0d rescan: valid=%b err=%b busy=%b id=%h h=%0d v=%0d, required valid=0 err=0 busy=1 id=%h h=%0d v=%0d",
                         name, d, o_valid[d], o_err[d], o_busy[d], o_id[d], o_h[d], o_v[d],
                         exp_id[d], exp_h[d], exp_v[d]);
            end
        end
    endtask

    // Drive the pattern from edge 1 to the predicted completion edge and check both DUTs
    task automatic run_detect(input string name, input bit ign);
        int done, ign_e;
        logic [2:0] rc;
        bit forced, bad;
        logic [15:0] id;
        logic [10:0] h, v;
        predict(done, rc, forced);
        ign_e = ign ? int'($urandom_range(done - 1, 1)) : -1;
        for (int e = 1; e <= done; e++) begin
            @(posedge clk); #1;
            rgb = make_rgb(pin_at(e));
            rescan = (e == ign_e);
            @(negedge clk);
            if (e == done - 1) begin
                for (int d = 0; d < 2; d++) begin
                    checks++;
                    if (o_busy[d] !== 1'b1 || o_valid[d] !== 1'b0 || o_err[d] !== 1'b0) begin
                        failures++;
                        $display("FAIL %s dut%0d early edge %0d: busy=%b valid=%b err=%b, required busy=1 valid=0 err=0",
                                 name, d, e, o_busy[d], o_valid[d], o_err[d]);
                    end
                end
            end
            if (e == done) begin
                for (int d = 0; d < 2; d++) begin
                    ref_decode(rc, (d == 0) ? EN0 : EN1, id, h, v, bad);
                    bad = bad | forced;
                    exp_valid[d] = !bad; exp_err[d] = bad; exp_code[d] = rc;
                    exp_id[d] = bad ? 16'h0 : id;
                    exp_h[d]  = bad ? 11'd0 : h;
                    exp_v[d]  = bad ? 11'd0 : v;
                    checks++;
                    if (o_valid[d] !== exp_valid[d] || o_err[d] !== exp_err[d] || o_id[d] !== exp_id[d] ||
                        o_h[d] !== exp_h[d] || o_v[d] !== exp_v[d] || o_code[d] !== exp_code[d] ||
                        o_busy[d] !== 1'b0) begin
                        failures++;
                        $display("FAIL %s dut%0d edge %0d: valid=%b err=%b id=%h h=%0d v=%0d code=%b busy=%b, required valid=%b err=%b id=%h h=%0d v=%0d code=%b busy=0",
                                 name, d, e, o_valid[d], o_err[d], o_id[d], o_h[d], o_v[d], o_code[d], o_busy[d],
                                 exp_valid[d], exp_err[d], exp_id[d], exp_h[d], exp_v[d], exp_code[d]);
                    end
                end
            end
        end
        rescan = 1'b0;
    endtask

    task automatic set_pat(input logic [2:0] a, input logic [2:0] b, input int c, input bit t);
        code_a = a; code_b = b; chg_at = c; tog = t;
    endtask

    task automatic test_reset();
        set_pat(3'b001, 3'b001, 0, 0);
        do_reset("reset");
    endtask

    task automatic test_first_decode();
        run_detect("code001", 0);
        checks++;
        if (o_id[0] !== 16'h7084 || o_h[0] !== 11'd800 || o_v[0] !== 11'd480 || o_valid[0] !== 1'b1) begin
            failures++;
            $display("FAIL first_7084: id=%h h=%0d v=%0d valid=%b, required id=7084 h=800 v=480 valid=1",
                     o_id[0], o_h[0], o_v[0], o_valid[0]);
        end
    endtask

    task automatic test_hold();
        repeat (4) begin
            @(posedge clk); #1 rgb = 16'($urandom);
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (o_id[d] !== exp_id[d] || o_code[d] !== exp_code[d] || o_valid[d] !== exp_valid[d] ||
                    o_err[d] !== exp_err[d] || o_busy[d] !== 1'b0 || (o_valid[d] & o_err[d]) !== 1'b0) begin
                    failures++;
                    $display("FAIL hold dut%0d: id=%h code=%b valid=%b err=%b busy=%b, required id=%h code=%b valid=%b err=%b busy=0",
                             d, o_id[d], o_code[d], o_valid[d], o_err[d], o_busy[d],
                             exp_id[d], exp_code[d], exp_valid[d], exp_err[d]);
                end
            end
        end
    endtask

    task automatic test_rescan();
        set_pat(3'b101, 3'b101, 0, 0);
        start_rescan("r101"); run_detect("code101", 0);
        set_pat(3'b000, 3'b000, 0, 0);
        start_rescan("r000"); run_detect("code000", 0);
        checks++;
        if (o_id[0] !== 16'h4342 || o_h[0] !== 11'd480 || o_v[0] !== 11'd272) begin
            failures++;
            $display("FAIL rescan_4342: id=%h h=%0d v=%0d, required id=4342 h=480 v=272", o_id[0], o_h[0], o_v[0]);
        end
    endtask

    task automatic test_error();
        logic [2:0] codes [4] = '{3'b111, 3'b010, 3'b011, 3'b110};
        for (int i = 0; i < 4; i++) begin
            set_pat(codes[i], codes[i], 0, 0);
            start_rescan("err_rescan");
            run_detect("error_code", 0);
        end
        checks++;
        if (o_err[1] !== 1'b1 || o_valid[1] !== 1'b0 || o_id[1] !== 16'h0) begin
            failures++;
            $display("FAIL err_110: err=%b valid=%b id=%h, required err=1 valid=0 id=0", o_err[1], o_valid[1], o_id[1]);
        end
    endtask

    task automatic test_retry();
        set_pat(3'b001, 3'b000, 3, 1);
        start_rescan("toggle"); run_detect("retry_err", 0);
        checks++;
        if (o_err[0] !== 1'b1 || o_valid[0] !== 1'b0) begin
            failures++;
            $display("FAIL retry_forced: err=%b valid=%b, required err=1 valid=0", o_err[0], o_valid[0]);
        end
        set_pat(3'b001, 3'b000, 3, 0);
        start_rescan("one_mis"); run_detect("retry_once", 0);
    endtask

    task automatic test_rescan_ignored();
        for (int i = 0; i < 4; i++) begin
            set_pat(3'($urandom_range(7, 0)), 3'($urandom_range(7, 0)), 0, 0);
            code_b = code_a;
            start_rescan("ign_start");
            run_detect("rescan_ignored", 1);
        end
    endtask

    task automatic test_async_reset();
        set_pat(3'b100, 3'b100, 0, 0);
        start_rescan("async_pre");
        for (int e = 1; e <= 6; e++) begin
            @(posedge clk); #1 rgb = make_rgb(pin_at(e));
        end
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (o_id[d] !== 16'h0 || o_code[d] !== 3'b000 || o_valid[d] !== 1'b0 ||
                o_err[d] !== 1'b0 || o_busy[d] !== 1'b1) begin
                failures++;
                $display("FAIL async_reset dut%0d: id=%h code=%b valid=%b err=%b busy=%b, required zeros with busy=1",
                         d, o_id[d], o_code[d], o_valid[d], o_err[d], o_busy[d]);
            end
        end
        do_reset("async_hold");
        run_detect("after_async", 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            set_pat(3'($urandom_range(7, 0)), 3'($urandom_range(7, 0)),
                    int'($urandom_range(12, 0)), bit'($urandom_range(1, 0)));
            start_rescan("rand_start");
            run_detect("random", bit'($urandom_range(1, 0)));
            if (i % 3 == 0) test_hold();
        end
    endtask

    initial begin
        test_reset();
        test_first_decode();
        test_hold();
        test_rescan();
        test_error();
        test_retry();
        test_async_reset();
        test_rescan_ignored();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
